// File: rtl/sign_pwm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sign_pwm_pkg
// Description : Shared state encoding and period helper for the sign/magnitude
//               PWM sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sign_pwm_pkg;

  // Channel control states: legs off, dead time, PWM running
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RUN  = 2'd2
  } pwm_state_t;

  // Last count value of a period for an m-bit magnitude (period is 2**m - 1)
  function automatic int period_max(input int m);
    return (2 ** m) - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sign_pwm_sequencer_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_period_counter
// Description : Period counter running 0..P-1 with a wrap flag raised in the
//               last cycle of each period. Clear holds it at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_period_counter
  import sign_pwm_pkg::*;
#(
  parameter int M = 3
) (
  input  logic         Clock,
  input  logic         nReset,
  input  logic         Clear,
  output logic [M-1:0] Count,
  output logic         Wrap
);

  localparam logic [M-1:0] CNT_MAX = M'(period_max(M));

  logic [M-1:0] count_q;
  logic [M-1:0] count_d;

  assign Wrap  = (count_q == CNT_MAX);
  assign Count = count_q;

  // Next count: restart at zero when cleared or at the end of a period
  always_comb begin
    count_d = count_q + 1'b1;
    if (Clear || Wrap) begin
      count_d = '0;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sign_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sign_pwm_sequencer
// Description : Sign/magnitude H-bridge PWM controller. Magnitude and sign are
//               sampled only at period boundaries; direction changes and every
//               start from disable insert a dead time with both legs low.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_pwm_sequencer
  import sign_pwm_pkg::*;
#(
  parameter int Size     = 4,
  parameter int DeadTime = 2
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Enable,
  input  logic [Size-2:0] PWMData,
  input  logic            Sign,
  output logic            OutA,
  output logic            OutB,
  output logic            PeriodStart,
  output logic            DeadActive
);

  localparam int M  = Size - 1;
  localparam int DW = $clog2(DeadTime + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DeadTime - 1);

  pwm_state_t   state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [M-1:0] duty_q, duty_d;
  logic [M-1:0] pduty_q, pduty_d;
  logic         asign_q, asign_d;
  logic         psign_q, psign_d;

  logic [M-1:0] count_q;
  logic [M-1:0] count_d;
  logic         wrap;
  logic         clear;

  logic outa_q, outb_q, pstart_q, dact_q;

  // The counter only advances while the channel stays in RUN across the edge
  assign clear = !((state_q == RUN) && (state_d == RUN));

  pwm_period_counter #(
    .M (M)
  ) u_period_counter (
    .Clock  (Clock),
    .nReset (nReset),
    .Clear  (clear),
    .Count  (count_q),
    .Wrap   (wrap)
  );

  // Next-state decode: disable aborts everything, boundary sampling in RUN
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    duty_d  = duty_q;
    asign_d = asign_q;
    pduty_d = pduty_q;
    psign_d = psign_q;
    if (!Enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD;
          pduty_d = PWMData;
          psign_d = Sign;
          dcnt_d  = DEAD_LOAD;
        end
        DEAD: begin
          if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - 1'b1;
          end else begin
            state_d = RUN;
            duty_d  = pduty_q;
            asign_d = psign_q;
          end
        end
        RUN: begin
          if (wrap) begin
            if (Sign == asign_q) begin
              duty_d = PWMData;
            end else begin
              pduty_d = PWMData;
              psign_d = Sign;
              dcnt_d  = DEAD_LOAD;
              state_d = DEAD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Mirror of the period counter's next value so outputs line up with Count
  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || wrap) begin
      count_d = '0;
    end
  end

  // State, data and output registers; outputs derive from next-state values
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q  <= IDLE;
      dcnt_q   <= '0;
      duty_q   <= '0;
      asign_q  <= 1'b0;
      pduty_q  <= '0;
      psign_q  <= 1'b0;
      outa_q   <= 1'b0;
      outb_q   <= 1'b0;
      pstart_q <= 1'b0;
      dact_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      duty_q   <= duty_d;
      asign_q  <= asign_d;
      pduty_q  <= pduty_d;
      psign_q  <= psign_d;
      outa_q   <= (state_d == RUN) &&  asign_d && (count_d < duty_d);
      outb_q   <= (state_d == RUN) && !asign_d && (count_d < duty_d);
      pstart_q <= (state_d == RUN) && (count_d == '0);
      dact_q   <= (state_d == DEAD);
    end
  end

  assign OutA        = outa_q;
  assign OutB        = outb_q;
  assign PeriodStart = pstart_q;
  assign DeadActive  = dact_q;

endmodule
`default_nettype wire
